// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default layer geometry and index-width helper for the layer sequencer.
package nn_pkg;
   localparam int N_INPUTS_DEF  = 4;
   localparam int N_NEURONS_DEF = 4;
   localparam int N_LAYERS_DEF  = 2;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_CLR  = 3'd1;
   localparam state_t S_ACC  = 3'd2;
   localparam state_t S_ACT  = 3'd3;
   localparam state_t S_WB   = 3'd4;
   localparam state_t S_DONE = 3'd5;
   // index width for a value range of n, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/nn_wrap_counter.sv
// nn_wrap_counter: index counter that wraps to zero after max, with synchronous clear and last flag.
module nn_wrap_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] value_o,
   output logic         last_o
);
   logic [W-1:0] value_q, value_d;
   assign last_o  = value_q == max_i;
   assign value_o = value_q;
   assign value_d = clr_i ? '0 : en_i ? (last_o ? '0 : value_q + 1'b1) : value_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) value_q <= '0;
      else        value_q <= value_d;
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: clear/accumulate/activate/write-back sequencer across N_LAYERS x N_NEURONS.
// Define NNSEQ_BIAS_EN to append a bias operand read as the final accumulate beat of each neuron.
module nn_layer_sequencer
   import nn_pkg::*;
#(
   parameter int N_INPUTS  = N_INPUTS_DEF,
   parameter int N_NEURONS = N_NEURONS_DEF,
   parameter int N_LAYERS  = N_LAYERS_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic                         stall_i,
   output logic                         ag_rst_o,
   output logic                         ag_read_o,
   output logic                         alu_rst_o,
   output logic [idx_w(N_INPUTS+1)-1:0] in_idx_o,
   output logic [idx_w(N_NEURONS)-1:0]  neuron_idx_o,
   output logic [idx_w(N_LAYERS)-1:0]   layer_idx_o,
   output logic                         act_en_o,
   output logic                         wr_en_o,
   output logic                         busy_o,
   output logic                         done_o
);
   localparam int IW = idx_w(N_INPUTS + 1);
   localparam int NW = idx_w(N_NEURONS);
   localparam int LW = idx_w(N_LAYERS);
`ifdef NNSEQ_BIAS_EN
   localparam int N_ACC = N_INPUTS + 1;
`else
   localparam int N_ACC = N_INPUTS;
`endif
   state_t state_q, state_d;
   logic   abt, in_last, nrn_last, lyr_last, acc_step, wb_step;
   assign busy_o   = state_q != S_IDLE;
   assign abt      = abort_i && busy_o;
   assign acc_step = state_q == S_ACC && !stall_i && !abt;
   assign wb_step  = state_q == S_WB && !abt;
   // strobes are suppressed in the cancelling cycle so an abort never leaks a write or done
   assign ag_rst_o  = state_q == S_CLR && !abt;
   assign alu_rst_o = state_q == S_CLR && !abt;
   assign ag_read_o = acc_step;
   assign act_en_o  = state_q == S_ACT && !abt;
   assign wr_en_o   = wb_step;
   assign done_o    = state_q == S_DONE && !abt;
   always_comb begin
      state_d = state_q;
      if (abt) state_d = S_IDLE;
      else
         case (state_q)
            S_IDLE:  state_d = start_i ? S_CLR : S_IDLE;
            S_CLR:   state_d = S_ACC;
            S_ACC:   state_d = (acc_step && in_last) ? S_ACT : S_ACC;
            S_ACT:   state_d = S_WB;
            S_WB:    state_d = (nrn_last && lyr_last) ? S_DONE : S_CLR;
            default: state_d = S_IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   // in_idx is only meaningful inside ACC; it is held at zero everywhere else
   nn_wrap_counter #(.W(IW)) u_in_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (acc_step),
      .clr_i   (abt || state_q != S_ACC),
      .max_i   (IW'(N_ACC - 1)),
      .value_o (in_idx_o),
      .last_o  (in_last)
   );
   nn_wrap_counter #(.W(NW)) u_nrn_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (wb_step),
      .clr_i   (abt),
      .max_i   (NW'(N_NEURONS - 1)),
      .value_o (neuron_idx_o),
      .last_o  (nrn_last)
   );
   nn_wrap_counter #(.W(LW)) u_lyr_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (wb_step && nrn_last),
      .clr_i   (abt),
      .max_i   (LW'(N_LAYERS - 1)),
      .value_o (layer_idx_o),
      .last_o  (lyr_last)
   );
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scoreboard bench; expected write-backs and done pulses are queued at stimulus time.
module tb_nn_layer_sequencer;
   localparam int NN = 4;
   localparam int NL = 2;
`ifdef NNSEQ_BIAS_EN
   localparam int NACC = 5;
   localparam int SACC = 4;
`else
   localparam int NACC = 4;
   localparam int SACC = 3;
`endif
   localparam int P = NACC + 3;
   typedef struct {
      bit is_done;
      int layer;
      int neuron;
      int cyc;
   } exp_t;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, stall = 1'b0;
   logic       ag_rst_o, ag_read_o, alu_rst_o, act_en_o, wr_en_o, busy_o, done_o;
   logic [2:0] in_idx_o;
   logic [1:0] neuron_idx_o;
   logic [0:0] layer_idx_o;
   logic       s_start = 1'b0;
   logic       s_ag_rst, s_ag_read, s_alu_rst, s_act_en, s_wr_en, s_busy, s_done;
   logic [1:0] s_in_idx;
   logic [0:0] s_neuron, s_layer;
   exp_t       q[$];
   int         cyc = 0, checks = 0, errors = 0, reads = 0;
   nn_layer_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .stall_i(stall),
      .ag_rst_o(ag_rst_o), .ag_read_o(ag_read_o), .alu_rst_o(alu_rst_o), .in_idx_o(in_idx_o),
      .neuron_idx_o(neuron_idx_o), .layer_idx_o(layer_idx_o), .act_en_o(act_en_o),
      .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o)
   );
   nn_layer_sequencer #(.N_INPUTS(3), .N_NEURONS(1), .N_LAYERS(1)) u_small (
      .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(1'b0), .stall_i(1'b0),
      .ag_rst_o(s_ag_rst), .ag_read_o(s_ag_read), .alu_rst_o(s_alu_rst), .in_idx_o(s_in_idx),
      .neuron_idx_o(s_neuron), .layer_idx_o(s_layer), .act_en_o(s_act_en),
      .wr_en_o(s_wr_en), .busy_o(s_busy), .done_o(s_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic logic [15:0] outs();
      return {3'b0, ag_rst_o, ag_read_o, alu_rst_o, act_en_o, wr_en_o, busy_o, done_o,
              in_idx_o, neuron_idx_o, layer_idx_o};
   endfunction
   // monitor: every write-back or done must match the head of the expectation queue
   always @(negedge clk) begin
      if (ag_read_o) reads++;
      if (wr_en_o || done_o) begin
         if (q.size() == 0) chk("unexpected_event", done_o ? 256 : layer_idx_o * 16 + neuron_idx_o, -1);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("event_id", done_o ? 256 : (wr_en_o ? layer_idx_o * 16 + neuron_idx_o : -2),
                e.is_done ? 256 : e.layer * 16 + e.neuron);
            chk("event_cycle", cyc, e.cyc);
         end
      end
   end
   task automatic push_run(input int t0, input int extra, input int nwr, input bit with_done);
      for (int k = 0; k < nwr; k++)
         q.push_back('{is_done: 1'b0, layer: k / NN, neuron: k % NN, cyc: t0 + P * (k + 1) + extra});
      if (with_done) q.push_back('{is_done: 1'b1, layer: 0, neuron: 0, cyc: t0 + NL * NN * P + 1 + extra});
   endtask
   task automatic start_run(output int t0);
      @(posedge clk); #1;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic wait_idle(input string name, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (busy_o && n < lim);
      chk(name, busy_o, 0);
   endtask
   initial begin
      int t0, r0, n, lat, rd, mx;
      bit found;
      @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      // plain run
      r0 = reads;
      start_run(t0);
      push_run(t0, 0, NL * NN, 1);
      chk("busy_in_run", busy_o, 1);
      wait_idle("run1_timeout", 200);
      chk("run1_queue_empty", q.size(), 0);
      chk("run1_reads", reads - r0, NL * NN * NACC);
      // stall three cycles in neuron 0 accumulate
      r0 = reads;
      start_run(t0);
      push_run(t0, 3, NL * NN, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         stall = 1'b1;
         @(negedge clk);
         chk("stall_read_low", ag_read_o, 0);
         chk("stall_idx_hold", in_idx_o, 0);
      end
      @(posedge clk); #1;
      stall = 1'b0;
      wait_idle("stall_timeout", 200);
      chk("stall_queue_empty", q.size(), 0);
      chk("stall_reads", reads - r0, NL * NN * NACC);
      // abort in ACT of layer 1 neuron 2
      start_run(t0);
      push_run(t0, 0, NN + 2, 0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = act_en_o && layer_idx_o == 1 && neuron_idx_o == 2;
      end
      chk("abort_target_found", found, 1);
      abort = 1'b1;
      #1 chk("abort_strobe_quiet", act_en_o, 0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", outs(), 0);
      repeat (80) @(negedge clk);
      chk("abort_queue_empty", q.size(), 0);
      // asynchronous reset in ACC of neuron 1
      start_run(t0);
      push_run(t0, 0, 1, 0);
      repeat (9) @(negedge clk);
      chk("pre_reset_read", ag_read_o, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", outs(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_resume", busy_o, 0);
      chk("reset_queue_empty", q.size(), 0);
      r0 = reads;
      start_run(t0);
      push_run(t0, 0, NL * NN, 1);
      wait_idle("post_reset_timeout", 200);
      chk("post_reset_queue_empty", q.size(), 0);
      chk("post_reset_reads", reads - r0, NL * NN * NACC);
      // start held across the whole run: second run starts from IDLE one cycle after done
      @(posedge clk); #1;
      start = 1'b1;
      t0 = cyc;
      push_run(t0, 0, NL * NN, 1);
      push_run(t0 + NL * NN * P + 2, 0, NL * NN, 1);
      repeat (NL * NN * P + 4) @(posedge clk);
      #1 start = 1'b0;
      wait_idle("held_timeout", 200);
      chk("held_queue_empty", q.size(), 0);
      // single-neuron single-layer instance
      @(posedge clk); #1;
      s_start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      s_start = 1'b0;
      lat = -1; rd = 0; mx = 0; n = 0;
      while (lat < 0 && n < 50) begin
         @(negedge clk);
         n++;
         if (s_ag_read) begin rd++; if (int'(s_in_idx) > mx) mx = int'(s_in_idx); end
         if (s_done) lat = cyc - t0;
      end
      chk("small_latency", lat, SACC + 4);
      chk("small_reads", rd, SACC);
      chk("small_max_idx", mx, SACC - 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
